// File: rtl/mc_bus_master_if.sv
// mc_bus_master_if: request/response handshake plus MCU parallel register bus signals
interface mc_bus_master_if #(
   parameter int MC_DATA_WIDTH = 16,
   parameter int MC_ADD_WIDTH  = 6
);
   logic                     req_valid;
   logic                     req_ready;
   logic                     req_write;
   logic [MC_ADD_WIDTH-1:0]  req_addr;
   logic [MC_DATA_WIDTH-1:0] req_wdata;
   logic                     rsp_valid;
   logic [MC_DATA_WIDTH-1:0] rsp_rdata;
   logic                     busy;
   logic                     mc_ce;
   logic                     mc_oe;
   logic                     mc_we;
   logic [MC_ADD_WIDTH-1:0]  mc_add;
   logic [MC_DATA_WIDTH-1:0] mc_data_o;
   logic                     mc_data_oe;
   logic [MC_DATA_WIDTH-1:0] mc_data_i;
   modport master (
      input  req_valid, req_write, req_addr, req_wdata, mc_data_i,
      output req_ready, rsp_valid, rsp_rdata, busy,
             mc_ce, mc_oe, mc_we, mc_add, mc_data_o, mc_data_oe
   );
   modport slave (
      output req_valid, req_write, req_addr, req_wdata, mc_data_i,
      input  req_ready, rsp_valid, rsp_rdata, busy,
             mc_ce, mc_oe, mc_we, mc_add, mc_data_o, mc_data_oe
   );
endinterface

// File: rtl/mc_bus_master.sv
// mc_bus_master: single-word initiator for the MCU register bus with setup/strobe/hold phases
module mc_bus_master #(
   parameter int MC_DATA_WIDTH = 16,
   parameter int MC_ADD_WIDTH  = 6,
   parameter int SETUP_CYC     = 2,
   parameter int STROBE_CYC    = 4,
   parameter int HOLD_CYC      = 1
) (
   input  logic           clk,
   input  logic           rst,
   mc_bus_master_if.master bus
);
   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
   localparam logic [7:0] SETUP_RL  = 8'(SETUP_CYC - 1);
   localparam logic [7:0] STROBE_RL = 8'(STROBE_CYC - 1);
   localparam logic [7:0] HOLD_RL   = 8'(HOLD_CYC - 1);
   state_t                   r_state;
   logic [7:0]               r_cnt;
   logic                     r_write;
   logic                     r_ready;
   logic                     r_busy;
   logic                     r_rsp_valid;
   logic [MC_DATA_WIDTH-1:0] r_rdata;
   logic                     r_ce;
   logic                     r_oe;
   logic                     r_we;
   logic [MC_ADD_WIDTH-1:0]  r_add;
   logic [MC_DATA_WIDTH-1:0] r_data_o;
   logic                     r_data_oe;
   logic                     w_last;
   assign w_last = r_cnt == 8'd0;
   // Phase sequencer; every bus output is a register updated on the phase transition edge
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_state     <= IDLE;
         r_cnt       <= 8'd0;
         r_write     <= 1'b0;
         r_ready     <= 1'b0;
         r_busy      <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rdata     <= '0;
         r_ce        <= 1'b1;
         r_oe        <= 1'b1;
         r_we        <= 1'b1;
         r_add       <= '0;
         r_data_o    <= '0;
         r_data_oe   <= 1'b0;
      end else begin
         r_rsp_valid <= 1'b0;
         if (!w_last) r_cnt <= r_cnt - 8'd1;
         case (r_state)
            IDLE: begin
               r_ready <= 1'b1;
               if (bus.req_valid && r_ready) begin
                  r_state <= SETUP;
                  r_cnt   <= SETUP_RL;
                  r_write <= bus.req_write;
                  r_add   <= bus.req_addr;
                  r_ce    <= 1'b0;
                  r_busy  <= 1'b1;
                  r_ready <= 1'b0;
                  if (bus.req_write) begin
                     r_data_o  <= bus.req_wdata;
                     r_data_oe <= 1'b1;
                  end
               end
            end
            SETUP: if (w_last) begin
               r_state <= STROBE;
               r_cnt   <= STROBE_RL;
               r_we    <= !r_write;
               r_oe    <= r_write;
            end
            STROBE: if (w_last) begin
               r_state <= HOLD;
               r_cnt   <= HOLD_RL;
               r_we    <= 1'b1;
               r_oe    <= 1'b1;
               if (!r_write) r_rdata <= bus.mc_data_i;
            end
            default: if (w_last) begin
               r_state     <= IDLE;
               r_ce        <= 1'b1;
               r_data_oe   <= 1'b0;
               r_busy      <= 1'b0;
               r_ready     <= 1'b1;
               r_rsp_valid <= 1'b1;
            end
         endcase
      end
   assign bus.req_ready  = r_ready;
   assign bus.rsp_valid  = r_rsp_valid;
   assign bus.rsp_rdata  = r_rdata;
   assign bus.busy       = r_busy;
   assign bus.mc_ce      = r_ce;
   assign bus.mc_oe      = r_oe;
   assign bus.mc_we      = r_we;
   assign bus.mc_add     = r_add;
   assign bus.mc_data_o  = r_data_o;
   assign bus.mc_data_oe = r_data_oe;
endmodule

// File: tb/tb_mc_bus_master.sv
// tb_mc_bus_master: directed checks of bus cycle timing, read capture, back-to-back and reset
module tb_mc_bus_master;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [5:0]  req_addr = 6'd0;
   logic [15:0] req_wdata = 16'd0;
   logic [15:0] rd_val = 16'h1234;
   logic        sel = 1'b0;
   int          checks = 0;
   int          failures = 0;
   int          n_ce, n_we, f_we, n_oe, f_oe, n_doe, n_rv, at_rv, bad, seg, gap;
   mc_bus_master_if b0 ();
   mc_bus_master_if b1 ();
   mc_bus_master u0 (.clk(clk), .rst(rst), .bus(b0));
   mc_bus_master #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
   always #5 clk = ~clk;
   assign b0.req_valid = req_valid;
   assign b0.req_write = req_write;
   assign b0.req_addr  = req_addr;
   assign b0.req_wdata = req_wdata;
   assign b0.mc_data_i = b0.mc_oe ? 16'hDEAD : rd_val;
   assign b1.req_valid = req_valid;
   assign b1.req_write = req_write;
   assign b1.req_addr  = req_addr;
   assign b1.req_wdata = req_wdata;
   assign b1.mc_data_i = b1.mc_oe ? 16'hDEAD : rd_val;
   logic        ce, oe, we, doe, rv, busy, ready;
   logic [5:0]  add;
   logic [15:0] dout, rdata;
   assign ce    = sel ? b1.mc_ce      : b0.mc_ce;
   assign oe    = sel ? b1.mc_oe      : b0.mc_oe;
   assign we    = sel ? b1.mc_we      : b0.mc_we;
   assign doe   = sel ? b1.mc_data_oe : b0.mc_data_oe;
   assign rv    = sel ? b1.rsp_valid  : b0.rsp_valid;
   assign busy  = sel ? b1.busy       : b0.busy;
   assign ready = sel ? b1.req_ready  : b0.req_ready;
   assign add   = sel ? b1.mc_add     : b0.mc_add;
   assign dout  = sel ? b1.mc_data_o  : b0.mc_data_o;
   assign rdata = sel ? b1.rsp_rdata  : b0.rsp_rdata;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int t = 0;
      while (!ready && t < 30) begin
         step();
         t++;
      end
      check("ready_wait", ready, 1);
   endtask

   task automatic txn(input logic w, input logic [5:0] a, input logic [15:0] d, input logic tog);
      wait_ready();
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      step();
      req_valid = 1'b0;
      req_write = !w;
      req_addr  = ~a;
      req_wdata = ~d;
      n_ce = 0; n_we = 0; f_we = 0; n_oe = 0; f_oe = 0; n_doe = 0; n_rv = 0; at_rv = 0; bad = 0;
      for (int c = 1; c <= 12; c++) begin
         if (!ce) n_ce++;
         if (!we) begin n_we++; if (f_we == 0) f_we = c; end
         if (!oe) begin n_oe++; if (f_oe == 0) f_oe = c; end
         if (doe) begin n_doe++; if (dout !== d) bad++; end
         if (rv) begin n_rv++; at_rv = c; end
         if (!ce && add !== a) bad++;
         if (!oe && !we) bad++;
         if (busy && ready) bad++;
         req_valid = tog && busy && (c % 2 == 1);
         step();
      end
      req_valid = 1'b0;
   endtask

   initial begin
      #1 rst = 1'b0;
      #1;
      check("rst_ce", ce, 1);
      check("rst_oe", oe, 1);
      check("rst_we", we, 1);
      check("rst_doe", doe, 0);
      check("rst_add", add, 0);
      check("rst_dout", dout, 0);
      check("rst_rdata", rdata, 0);
      check("rst_rv", rv, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", ready, 0);
      #1 rst = 1'b1;
      #1 check("rel_ready_pre_edge", ready, 0);
      step();
      check("rel_ready_post_edge", ready, 1);
      // default write
      txn(1'b1, 6'h15, 16'hA5C3, 1'b0);
      check("wr_ce_len", n_ce, 7);
      check("wr_we_len", n_we, 4);
      check("wr_we_first", f_we, 3);
      check("wr_oe_len", n_oe, 0);
      check("wr_doe_len", n_doe, 7);
      check("wr_rv_cnt", n_rv, 1);
      check("wr_rv_at", at_rv, 8);
      check("wr_bad", bad, 0);
      // default read
      txn(1'b0, 6'h2A, 16'h0000, 1'b0);
      check("rd_oe_len", n_oe, 4);
      check("rd_oe_first", f_oe, 3);
      check("rd_we_len", n_we, 0);
      check("rd_doe_len", n_doe, 0);
      check("rd_ce_len", n_ce, 7);
      check("rd_rv_cnt", n_rv, 1);
      check("rd_rdata", rdata, 16'h1234);
      check("rd_bad", bad, 0);
      // write with req_valid toggling while busy; rdata must not move
      rd_val = 16'h5555;
      txn(1'b1, 6'h3F, 16'h0F0F, 1'b1);
      check("tog_ce_len", n_ce, 7);
      check("tog_rv_cnt", n_rv, 1);
      check("tog_bad", bad, 0);
      check("tog_idle_ce", ce, 1);
      check("tog_idle_busy", busy, 0);
      check("tog_rdata_kept", rdata, 16'h1234);
      // back-to-back with req_valid held
      rd_val = 16'hBEEF;
      wait_ready();
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 6'h01;
      req_wdata = 16'hFFFF;
      step();
      req_write = 1'b0;
      req_addr  = 6'h02;
      req_wdata = 16'h0000;
      seg = 0; gap = 0; n_rv = 0; n_oe = 0; bad = 0;
      for (int c = 1; c <= 25; c++) begin
         if (seg == 0 && ce) seg = 1;
         if (seg == 1 && !ce) begin seg = 2; req_valid = 1'b0; end
         if (seg == 0 && (add !== 6'h01 || !doe || dout !== 16'hFFFF)) bad++;
         if (seg == 1) gap++;
         if (seg == 2 && !ce && (add !== 6'h02 || doe)) bad++;
         if (!oe) n_oe++;
         if (rv) n_rv++;
         step();
      end
      req_valid = 1'b0;
      check("b2b_second_seen", seg, 2);
      check("b2b_ce_gap", gap, 1);
      check("b2b_rv_cnt", n_rv, 2);
      check("b2b_oe_len", n_oe, 4);
      check("b2b_bad", bad, 0);
      check("b2b_rdata", rdata, 16'hBEEF);
      // reset during the second strobe cycle of a write
      wait_ready();
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 6'h0A;
      req_wdata = 16'h1111;
      step();
      req_valid = 1'b0;
      step();
      step();
      step();
      check("mid_we_low", we, 0);
      #2 rst = 1'b0;
      #1;
      check("mid_ce", ce, 1);
      check("mid_we", we, 1);
      check("mid_doe", doe, 0);
      check("mid_busy", busy, 0);
      check("mid_ready", ready, 0);
      #2 rst = 1'b1;
      #1 check("mid_ready_released", ready, 0);
      n_rv = 0;
      step();
      check("mid_ready_edge", ready, 1);
      for (int c = 0; c < 8; c++) begin
         if (rv) n_rv++;
         step();
      end
      check("mid_no_rv", n_rv, 0);
      txn(1'b1, 6'h0B, 16'h2222, 1'b0);
      check("post_ce_len", n_ce, 7);
      check("post_rv_cnt", n_rv, 1);
      check("post_bad", bad, 0);
      // 1/1/1 timing
      sel = 1'b1;
      #1;
      txn(1'b1, 6'h07, 16'h0707, 1'b0);
      check("min_wr_ce_len", n_ce, 3);
      check("min_wr_we_len", n_we, 1);
      check("min_wr_we_first", f_we, 2);
      check("min_wr_rv_at", at_rv, 4);
      check("min_wr_bad", bad, 0);
      rd_val = 16'h4321;
      txn(1'b0, 6'h08, 16'h0000, 1'b0);
      check("min_rd_oe_len", n_oe, 1);
      check("min_rd_oe_first", f_oe, 2);
      check("min_rd_doe_len", n_doe, 0);
      check("min_rd_rdata", rdata, 16'h4321);
      check("min_rd_rv_at", at_rv, 4);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
